// File: rtl/memory_access_arbiter_if.sv
// rtl/memory_access_arbiter_if.sv - requester and external memory bus bundle for memory_access_arbiter
interface memory_access_arbiter_if;
  logic        req0_valid;
  logic        req0_write;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_done;
  logic [31:0] req0_rdata;

  logic        req1_valid;
  logic        req1_write;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_done;
  logic [31:0] req1_rdata;

  logic        pause;
  logic        ext_control;
  logic [31:0] ext_address;
  logic [31:0] ext_data;
  logic [2:0]  ext_read_mode;
  logic [2:0]  ext_write_mode;
  logic [31:0] ext_data_out;
  logic        busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  ext_data_out,
    output req0_done, req0_rdata, req1_done, req1_rdata,
    output pause, ext_control, ext_address, ext_data,
    output ext_read_mode, ext_write_mode, busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output ext_data_out,
    input  req0_done, req0_rdata, req1_done, req1_rdata,
    input  pause, ext_control, ext_address, ext_data,
    input  ext_read_mode, ext_write_mode, busy
  );
endinterface

// File: rtl/memory_access_arbiter.sv
// rtl/memory_access_arbiter.sv - round-robin two-port arbiter and sequencer for the external memory port
module memory_access_arbiter #(
  parameter int PAUSE_SETTLE = 2,
  parameter int READ_LATENCY = 2
) (
  input logic                    clk,
  input logic                    rst,
  memory_access_arbiter_if.slave bus
);
  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_WORD = 3'd2;

  typedef enum logic [1:0] {IDLE, SETTLE, ACCESS, RESPOND} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cur_port;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        last_grant;

  logic        pause_q;
  logic        busy_q;
  logic        ext_control_q;
  logic        done0_q;
  logic        done1_q;
  logic [2:0]  read_mode_q;
  logic [2:0]  write_mode_q;
  logic [31:0] ext_address_q;
  logic [31:0] ext_data_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        idle_any;
  logic        other_valid;
  logic        grant_port;
  logic        g_write;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        launch;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

  // In RESPOND only the other port may be granted, so one port cannot starve the other.
  always_comb begin
    idle_any    = bus.req0_valid | bus.req1_valid;
    other_valid = cur_port ? bus.req0_valid : bus.req1_valid;
    if (state == RESPOND)
      grant_port = ~cur_port;
    else if (bus.req0_valid && bus.req1_valid)
      grant_port = ~last_grant;
    else
      grant_port = bus.req1_valid;
    g_write   = grant_port ? bus.req1_write : bus.req0_write;
    g_addr    = grant_port ? bus.req1_addr  : bus.req0_addr;
    g_wdata   = grant_port ? bus.req1_wdata : bus.req0_wdata;
    launch    = ((state == SETTLE) && (cnt == 4'd1)) || ((state == RESPOND) && other_valid);
    acc_write = (state == RESPOND) ? g_write : cur_write;
    acc_addr  = (state == RESPOND) ? g_addr  : cur_addr;
    acc_wdata = (state == RESPOND) ? g_wdata : cur_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      cur_port      <= 1'b0;
      cur_write     <= 1'b0;
      cur_addr      <= 32'd0;
      cur_wdata     <= 32'd0;
      last_grant    <= 1'b1;
      pause_q       <= 1'b0;
      busy_q        <= 1'b0;
      ext_control_q <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      read_mode_q   <= MODE_NONE;
      write_mode_q  <= MODE_NONE;
      ext_address_q <= 32'd0;
      ext_data_q    <= 32'd0;
      rdata0_q      <= 32'd0;
      rdata1_q      <= 32'd0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_any) begin
            cur_port   <= grant_port;
            cur_write  <= g_write;
            cur_addr   <= g_addr;
            cur_wdata  <= g_wdata;
            last_grant <= grant_port;
            cnt        <= 4'(PAUSE_SETTLE);
            pause_q    <= 1'b1;
            busy_q     <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != 4'd1)
            cnt <= cnt - 4'd1;
        end
        ACCESS: begin
          if (cnt == 4'd1) begin
            ext_control_q <= 1'b0;
            read_mode_q   <= MODE_NONE;
            write_mode_q  <= MODE_NONE;
            state         <= RESPOND;
            if (cur_port) begin
              done1_q <= 1'b1;
              if (!cur_write)
                rdata1_q <= bus.ext_data_out;
            end else begin
              done0_q <= 1'b1;
              if (!cur_write)
                rdata0_q <= bus.ext_data_out;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESPOND: begin
          if (other_valid) begin
            cur_port   <= grant_port;
            cur_write  <= g_write;
            cur_addr   <= g_addr;
            cur_wdata  <= g_wdata;
            last_grant <= grant_port;
          end else begin
            pause_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Shared access launch: end of SETTLE, or a back-to-back grant from RESPOND.
      if (launch) begin
        state         <= ACCESS;
        ext_control_q <= 1'b1;
        ext_address_q <= acc_addr;
        ext_data_q    <= acc_wdata;
        write_mode_q  <= acc_write ? MODE_WORD : MODE_NONE;
        read_mode_q   <= acc_write ? MODE_NONE : MODE_WORD;
        cnt           <= acc_write ? 4'd1 : 4'(READ_LATENCY);
      end
    end
  end

  assign bus.pause          = pause_q;
  assign bus.busy           = busy_q;
  assign bus.ext_control    = ext_control_q;
  assign bus.ext_address    = ext_address_q;
  assign bus.ext_data       = ext_data_q;
  assign bus.ext_read_mode  = read_mode_q;
  assign bus.ext_write_mode = write_mode_q;
  assign bus.req0_done      = done0_q;
  assign bus.req1_done      = done1_q;
  assign bus.req0_rdata     = rdata0_q;
  assign bus.req1_rdata     = rdata1_q;
endmodule
